// File: rtl/tlc_timer_pkg.sv
// Shared types, defaults and packing helper for the multi-channel phase timer.
package tlc_timer_pkg;

    // Per-channel counting mode selected by the auto_rl input bit.
    typedef enum logic {
        MODE_ONESHOT    = 1'b0,
        MODE_AUTORELOAD = 1'b1
    } mode_e;

    localparam int unsigned DefN      = 4;
    localparam int unsigned DefNumCh  = 4;
    localparam int unsigned DefPre    = 4;
    // Upper bounds: channel width up to 16 bits, up to 16 channels.
    localparam int unsigned MaxN      = 16;
    localparam int unsigned MaxW      = 256;

    // Extract channel idx of a packed vector whose channels are width bits wide.
    // The caller zero-extends its vector to MaxW bits and truncates the result.
    function automatic logic [MaxN-1:0] get_ch(input logic [MaxW-1:0] vec,
                                               input int unsigned idx,
                                               input int unsigned width);
        logic [MaxW-1:0] sh;
        logic [MaxN-1:0] mask;
        sh   = vec >> (idx * width);
        mask = (width >= MaxN) ? '1 : ((MaxN'(1) << width) - MaxN'(1));
        return sh[MaxN-1:0] & mask;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: count, reload value and registered done pulse.
module timer_channel
    import tlc_timer_pkg::*;
#(
    parameter int unsigned N = DefN
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_tick,
    input  logic         i_en,
    input  logic         i_load,
    input  logic         i_auto_rl,
    input  logic [N-1:0] i_init,
    output logic [N-1:0] o_count,
    output logic         o_done,
    output logic         o_expired
);

    logic [N-1:0] r_count;
    logic [N-1:0] w_count_d;
    logic [N-1:0] r_reload;
    logic [N-1:0] w_reload_d;
    logic         r_done;
    logic         w_done_d;
    mode_e        w_mode;

    assign w_mode = i_auto_rl ? MODE_AUTORELOAD : MODE_ONESHOT;

    // Next state: load beats counting; done only on the 1 -> 0 step.
    always_comb begin
        w_count_d  = r_count;
        w_reload_d = r_reload;
        w_done_d   = 1'b0;
        if (i_load) begin
            w_count_d  = i_init;
            w_reload_d = i_init;
        end else if (i_tick && i_en) begin
            if (r_count > N'(1)) begin
                w_count_d = r_count - N'(1);
            end else if (r_count == N'(1)) begin
                w_count_d = '0;
                w_done_d  = 1'b1;
            end else if (w_mode == MODE_AUTORELOAD) begin
                // Reload from 0 gives a period of reload+1 ticks; reload 0 stays at 0.
                w_count_d = r_reload;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count  <= '0;
            r_reload <= '0;
            r_done   <= 1'b0;
        end else begin
            r_count  <= w_count_d;
            r_reload <= w_reload_d;
            r_done   <= w_done_d;
        end
    end

    assign o_count   = r_count;
    assign o_done    = r_done;
    assign o_expired = (r_count == '0);

endmodule

// File: rtl/multi_timer.sv
// NUM_CH independent down-counters sharing one tick. Optional tick prescaler is
// enabled by defining MTIMER_PRESCALE_EN; otherwise every clk_en is a tick.
module multi_timer
    import tlc_timer_pkg::*;
#(
    parameter int unsigned N        = DefN,
    parameter int unsigned NUM_CH   = DefNumCh,
    parameter int unsigned PRESCALE = DefPre
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic [NUM_CH-1:0]     en,
    input  logic [NUM_CH-1:0]     load,
    input  logic [NUM_CH-1:0]     auto_rl,
    input  logic [NUM_CH*N-1:0]   init,
    output logic [NUM_CH*N-1:0]   out,
    output logic [NUM_CH-1:0]     done,
    output logic [NUM_CH-1:0]     expired
);

    localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
`ifdef MTIMER_PRESCALE_EN
    localparam int unsigned PreDiv = (PRESCALE < 1) ? 1 : PRESCALE;
`else
    // Divide-by-one: the prescale counter stays at 0 and tick follows clk_en.
    localparam int unsigned PreDiv = 1;
`endif

    logic [PreW-1:0]   r_pre;
    logic [PreW-1:0]   w_pre_d;
    logic              w_tick;
    logic [MaxW-1:0]   w_init_ext;

    // Prescale counter next state; tick fires on the clk_en that wraps it to 0.
    always_comb begin
        w_pre_d = r_pre;
        w_tick  = 1'b0;
        if (clk_en) begin
            if (r_pre == PreW'(PreDiv - 1)) begin
                w_pre_d = '0;
                w_tick  = 1'b1;
            end else begin
                w_pre_d = r_pre + PreW'(1);
            end
        end
    end

    // Prescale counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
        end else begin
            r_pre <= w_pre_d;
        end
    end

    assign w_init_ext = MaxW'(init);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [N-1:0] w_init_ch;
        logic [N-1:0] w_count;

        assign w_init_ch = N'(get_ch(w_init_ext, g, N));

        timer_channel #(
            .N (N)
        ) u_ch (
            .i_clk     (clk),
            .i_rst     (rst),
            .i_tick    (w_tick),
            .i_en      (en[g]),
            .i_load    (load[g]),
            .i_auto_rl (auto_rl[g]),
            .i_init    (w_init_ch),
            .o_count   (w_count),
            .o_done    (done[g]),
            .o_expired (expired[g])
        );

        assign out[g*N +: N] = w_count;
    end

endmodule

// File: tb/tb_multi_timer.sv
// Scoreboard bench for multi_timer. Stimulus pushes expected per-channel state for the
// next cycle; a negedge monitor pops and compares. Define MTIMER_PRESCALE_EN for the
// prescaled build (PRESCALE=4).
module tb_multi_timer;
    import tlc_timer_pkg::*;

    localparam int unsigned TN  = 4;
    localparam int unsigned TCH = 4;
`ifdef MTIMER_PRESCALE_EN
    localparam int Pre = 4;
`else
    localparam int Pre = 1;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                clk_en = 1'b0;
    logic [TCH-1:0]      en = '0;
    logic [TCH-1:0]      load = '0;
    logic [TCH-1:0]      auto_rl = '0;
    logic [TCH*TN-1:0]   init = '0;
    logic [TCH*TN-1:0]   out;
    logic [TCH-1:0]      done;
    logic [TCH-1:0]      expired;

    multi_timer #(
        .N        (TN),
        .NUM_CH   (TCH),
        .PRESCALE (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (clk_en),
        .en      (en),
        .load    (load),
        .auto_rl (auto_rl),
        .init    (init),
        .out     (out),
        .done    (done),
        .expired (expired)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard queues (parallel fields of one expectation).
    int          q_cyc[$];
    int          q_ch[$];
    logic [3:0]  q_cnt[$];
    logic        q_dn[$];
    logic        q_ex[$];
    string       q_nm[$];

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]  ar_seq [6] = '{4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2};
    logic [3:0]  c3_seq [10] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};

    // Expectation for the state visible after the next active edge.
    task automatic push_exp(input int ch, input logic [3:0] cnt, input logic dn,
                            input logic ex, input string nm);
        q_cyc.push_back(cyc + 1);
        q_ch.push_back(ch);
        q_cnt.push_back(cnt);
        q_dn.push_back(dn);
        q_ex.push_back(ex);
        q_nm.push_back(nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_clr();
        step();
        clk_en = 1'b0;
        load   = '0;
        rst    = 1'b0;
    endtask

    // Issue Pre clk_en pulses spaced gap clocks apart; the last pulse is left pending.
    task automatic advance(input int gap);
        for (int p = 0; p < Pre; p++) begin
            for (int s = 1; s < gap; s++) begin
                clk_en = 1'b0;
                step();
            end
            clk_en = 1'b1;
            if (p < Pre - 1) step();
        end
    endtask

    task automatic set_init(input int ch, input logic [3:0] val);
        init[ch*TN +: TN] = val;
    endtask

    // Monitor: compare every expectation due this cycle.
    int              m_cyc;
    int              m_ch;
    logic [3:0]      m_cnt;
    logic            m_dn;
    logic            m_ex;
    string           m_nm;
    logic [MaxN-1:0] m_a16;
    logic [3:0]      m_act;

    always @(negedge clk) begin
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            m_cyc = q_cyc.pop_front();
            m_ch  = q_ch.pop_front();
            m_cnt = q_cnt.pop_front();
            m_dn  = q_dn.pop_front();
            m_ex  = q_ex.pop_front();
            m_nm  = q_nm.pop_front();
            m_a16 = get_ch(MaxW'(out), m_ch, TN);
            m_act = m_a16[3:0];
            n_tests++;
            if (m_cyc != cyc || m_act !== m_cnt || done[m_ch] !== m_dn
                || expired[m_ch] !== m_ex) begin
                n_fail++;
                $display("FAIL %s (ch%0d cyc %0d/%0d): got out=%0d done=%b expired=%b, want out=%0d done=%b expired=%b",
                         m_nm, m_ch, cyc, m_cyc, m_act, done[m_ch], expired[m_ch],
                         m_cnt, m_dn, m_ex);
            end
        end
    end

    initial begin
        // Reset held two clocks; a load during reset is ignored.
        step();
        load = 4'b0001;
        set_init(0, 4'd7);
        for (int c = 0; c < TCH; c++) push_exp(c, 4'd0, 1'b0, 1'b1, "rst_state");
        step();
        push_exp(0, 4'd0, 1'b0, 1'b1, "rst_load_ignored");
        step();
        rst  = 1'b0;
        load = '0;

        // One-shot on ch0, clk_en every 4th clock.
        init = '0;
        set_init(0, 4'd3);
        load  = 4'b0001;
        en[0] = 1'b1;
        push_exp(0, 4'd3, 1'b0, 1'b0, "os_load");
        step_clr();
        advance(4); push_exp(0, 4'd2, 1'b0, 1'b0, "os_t1"); step_clr();
        advance(4); push_exp(0, 4'd1, 1'b0, 1'b0, "os_t2"); step_clr();
        advance(4); push_exp(0, 4'd0, 1'b1, 1'b1, "os_done"); step_clr();
        push_exp(0, 4'd0, 1'b0, 1'b1, "os_done_clr");
        step();
        advance(4); push_exp(0, 4'd0, 1'b0, 1'b1, "os_hold"); step_clr();
        push_exp(0, 4'd0, 1'b0, 1'b1, "os_hold_nodone");
        step();

        // Auto-reload on ch1, init 2: period of 3 ticks.
        auto_rl[1] = 1'b1;
        en[1]      = 1'b1;
        set_init(1, 4'd2);
        load = 4'b0010;
        push_exp(1, 4'd2, 1'b0, 1'b0, "ar_load");
        step_clr();
        for (int k = 0; k < 6; k++) begin
            advance(2);
            push_exp(1, ar_seq[k], (k == 1 || k == 4), (ar_seq[k] == 4'd0), "ar_tick");
            step_clr();
            push_exp(1, ar_seq[k], 1'b0, (ar_seq[k] == 4'd0), "ar_hold");
        end
        step();
        en[1]      = 1'b0;
        auto_rl[1] = 1'b0;

        // Pause ch2 at 3 while ch3 (loaded the same cycle) keeps counting.
        set_init(2, 4'd5);
        set_init(3, 4'd7);
        load  = 4'b1100;
        en[2] = 1'b1;
        en[3] = 1'b1;
        push_exp(2, 4'd5, 1'b0, 1'b0, "ind_ch2_load");
        push_exp(3, 4'd7, 1'b0, 1'b0, "ind_ch3_load");
        step_clr();
        advance(2);
        push_exp(2, 4'd4, 1'b0, 1'b0, "ind_ch2");
        push_exp(3, 4'd6, 1'b0, 1'b0, "ind_ch3");
        step_clr();
        advance(2);
        push_exp(2, 4'd3, 1'b0, 1'b0, "ind_ch2");
        push_exp(3, 4'd5, 1'b0, 1'b0, "ind_ch3");
        step_clr();
        en[2] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            advance(2);
            push_exp(2, 4'd3, 1'b0, 1'b0, "pause_hold");
            push_exp(3, c3_seq[i], (i == 4), (c3_seq[i] == 4'd0), "ind_ch3_run");
            step_clr();
        end
        en[2] = 1'b1;
        advance(2); push_exp(2, 4'd2, 1'b0, 1'b0, "resume_t1"); step_clr();
        advance(2); push_exp(2, 4'd1, 1'b0, 1'b0, "resume_t2"); step_clr();
        advance(2); push_exp(2, 4'd0, 1'b1, 1'b1, "resume_done"); step_clr();

        // Load beats a tick at count 1; no done pulse.
        set_init(0, 4'd2);
        load = 4'b0001;
        push_exp(0, 4'd2, 1'b0, 1'b0, "prio_setup");
        step_clr();
        advance(2); push_exp(0, 4'd1, 1'b0, 1'b0, "prio_at1"); step_clr();
        advance(2);
        set_init(0, 4'd4);
        load = 4'b0001;
        push_exp(0, 4'd4, 1'b0, 1'b0, "ld_prio");
        step_clr();
        push_exp(0, 4'd4, 1'b0, 1'b0, "ld_prio_nodone");
        step();

        // Load 0 in auto-reload mode: stays at 0, never pulses done.
        auto_rl[0] = 1'b1;
        set_init(0, 4'd0);
        load = 4'b0001;
        push_exp(0, 4'd0, 1'b0, 1'b1, "ld0_auto");
        step_clr();
        for (int k = 0; k < 3; k++) begin
            advance(2);
            push_exp(0, 4'd0, 1'b0, 1'b1, "ld0_auto_tick");
            step_clr();
            push_exp(0, 4'd0, 1'b0, 1'b1, "ld0_auto_after");
        end
        step();

        // Reset mid-count overrides a simultaneous load and tick.
        set_init(2, 4'd9);
        load = 4'b0100;
        push_exp(2, 4'd9, 1'b0, 1'b0, "rstmid_load");
        step_clr();
        advance(2); push_exp(2, 4'd8, 1'b0, 1'b0, "rstmid_t1"); step_clr();
        advance(2);
        rst  = 1'b1;
        load = 4'b0100;
        set_init(2, 4'd5);
        push_exp(2, 4'd0, 1'b0, 1'b1, "rstmid_ch2");
        push_exp(1, 4'd0, 1'b0, 1'b1, "rstmid_ch1");
        step_clr();
        advance(2); push_exp(2, 4'd0, 1'b0, 1'b1, "rstmid_after"); step_clr();

`ifdef MTIMER_PRESCALE_EN
        // One count per 4 clk_en pulses; reset clears a partly advanced prescaler.
        set_init(1, 4'd2);
        en[1] = 1'b1;
        load  = 4'b0010;
        push_exp(1, 4'd2, 1'b0, 1'b0, "pre_load");
        step_clr();
        for (int j = 0; j < 3; j++) begin
            clk_en = 1'b1; push_exp(1, 4'd2, 1'b0, 1'b0, "pre_hold"); step_clr();
        end
        clk_en = 1'b1; push_exp(1, 4'd1, 1'b0, 1'b0, "pre_tick"); step_clr();
        clk_en = 1'b1; step_clr();
        clk_en = 1'b1; step_clr();
        clk_en = 1'b1;
        rst    = 1'b1;
        push_exp(1, 4'd0, 1'b0, 1'b1, "pre_rst");
        step_clr();
        load = 4'b0010;
        push_exp(1, 4'd2, 1'b0, 1'b0, "pre_reload");
        step_clr();
        for (int j = 0; j < 3; j++) begin
            clk_en = 1'b1; push_exp(1, 4'd2, 1'b0, 1'b0, "pre_rst_hold"); step_clr();
        end
        clk_en = 1'b1; push_exp(1, 4'd1, 1'b0, 1'b0, "pre_rst_tick"); step_clr();
`endif

        // Let the monitor drain, bounded.
        for (int w = 0; w < 5 && q_cyc.size() > 0; w++) step();
        if (q_cyc.size() > 0) begin
            $display("FAIL scoreboard_drain: got %0d pending expectations, want 0",
                     q_cyc.size());
            n_fail += q_cyc.size();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
